// File: rtl/vedic_divider.sv
// vedic_divider: sequential restoring divider with do/done handshake; optional VEDIC_DIV_ZERO_FAST_EN shortens divide-by-zero
//   i_clk, i_reset (sync, active-low), i_a dividend, i_b divisor, i_do start
//   o_quotient, o_remainder, o_div_zero, o_busy, o_done (single-cycle pulse)
module vedic_divider #(
  parameter int DIVIDEND_W = 4,
  parameter int DIVISOR_W  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DIVIDEND_W-1:0] i_a,
  input  logic [DIVISOR_W-1:0]  i_b,
  input  logic                  i_do,
  output logic [DIVIDEND_W-1:0] o_quotient,
  output logic [DIVISOR_W-1:0]  o_remainder,
  output logic                  o_div_zero,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int CW = $clog2(DIVIDEND_W + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t r_state, w_next;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVISOR_W-1:0]  r_b, r_pr, r_alo;
  logic [DIVISOR_W:0]    w_sh;
  logic [CW-1:0]         r_cnt;
  logic                  w_ge, w_zero_fast, w_dz, w_acc;
`ifdef VEDIC_DIV_ZERO_FAST_EN
  // a zero divisor needs no iterations; one RUN hop keeps the two-edge latency
  assign w_zero_fast = (i_b == '0);
`else
  assign w_zero_fast = 1'b0;
`endif
  assign w_acc = (r_state == IDLE) && i_do;
  // guard bit in w_sh keeps the compare exact; after a subtract the remainder is below b, so it fits r_pr
  assign w_sh  = {r_pr, r_q[DIVIDEND_W-1]};
  assign w_ge  = w_sh >= {1'b0, r_b};
  assign w_dz  = (r_b == '0);
  always_comb begin
    w_next = r_state;
    if (w_acc) w_next = RUN;
    if (r_state == RUN && r_cnt == CW'(1)) w_next = FIN;
    if (r_state == FIN) w_next = IDLE;
  end
  always_ff @(posedge i_clk) r_state <= !i_reset ? IDLE : w_next;
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_q         <= '0;
      r_b         <= '0;
      r_pr        <= '0;
      r_alo       <= '0;
      r_cnt       <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_div_zero  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_done <= (r_state == FIN);
      if (w_acc) begin
        r_q    <= i_a;
        r_b    <= i_b;
        r_alo  <= i_a[DIVISOR_W-1:0];
        r_pr   <= '0;
        r_cnt  <= w_zero_fast ? CW'(1) : CW'(DIVIDEND_W);
        o_busy <= 1'b1;
      end
      if (r_state == RUN) begin
        r_pr  <= w_ge ? DIVISOR_W'(w_sh - {1'b0, r_b}) : w_sh[DIVISOR_W-1:0];
        r_q   <= {r_q[DIVIDEND_W-2:0], w_ge};
        r_cnt <= r_cnt - CW'(1);
      end
      if (r_state == FIN) begin
        o_quotient  <= w_dz ? '1 : r_q;
        o_remainder <= w_dz ? r_alo : r_pr;
        o_div_zero  <= w_dz;
        o_busy      <= 1'b0;
      end
    end
  end
endmodule
